inv_aes_round_ctrl: RTL and testbench
=====================================

INV_AES_ROUND_CTRL -- requirements
Module: inv_aes_round_ctrl

Interface
REQ-001 SHALL have parameter NR, default 10: number of inverse rounds.
REQ-002 SHALL have parameter STEP_CYCLES, default 4: cycles per round, legal range 1..15, covering datapath pipeline depth.
REQ-003 SHALL have port CLK  in  1  sole clock, rising edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  in  1  ciphertext offered.
REQ-006 SHALL have port in_ready  out  1  controller can accept.
REQ-007 SHALL have port in_data  in  128  ciphertext block.
REQ-008 SHALL have port abort  in  1  cancel current decryption.
REQ-009 SHALL have port dp_data  out  128  registered ciphertext to datapath.
REQ-010 SHALL have port key_idx  out  4  round-key index to key schedule.
REQ-011 SHALL have port dp_round  out  4  current round number to datapath.
REQ-012 SHALL have port dp_load  out  1  select initial-AddRoundKey path.
REQ-013 SHALL have port dp_last  out  1  final round, skip InvMixColumns.
REQ-014 SHALL have port dp_result  in  128  datapath output.
REQ-015 SHALL have port out_valid  out  1  plaintext available.
REQ-016 SHALL have port out_ready  in  1  consumer accepts.
REQ-017 SHALL have port out_data  out  128  plaintext block.
REQ-018 SHALL have port busy  out  1  high in RUN or DONE.

Function
REQ-019 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-020 SHALL drive in_ready = (state==IDLE) && RST; accept on in_valid && in_ready and register in_data into dp_data, round=0, step=0, enter RUN.
REQ-021 SHALL hold dp_data constant for the whole of RUN.
REQ-022 SHALL, in RUN, hold each round r (0..NR-1) for exactly STEP_CYCLES cycles; step wraps STEP_CYCLES-1 -> 0 and increments r.
REQ-023 SHALL drive in RUN: dp_round=r, key_idx=NR-1-r, dp_load=(r==0), dp_last=(r==NR-1); outside RUN all four SHALL be 0.
REQ-024 SHALL, on the edge ending step STEP_CYCLES-1 of round NR-1, register dp_result into out_data, set out_valid, and enter DONE.
REQ-025 SHALL produce out_valid exactly NR*STEP_CYCLES+1 cycles after the accept edge (41 at defaults).
REQ-026 SHALL hold out_valid and out_data stable in DONE until out_ready; on out_valid && out_ready clear out_valid and return to IDLE.
REQ-027 SHALL NOT accept in DONE (in_ready=0); next accept is earliest one cycle after output handshake.
REQ-028 SHALL, on abort in RUN, return to IDLE next edge with out_valid=0 and out_data unchanged; abort in IDLE or DONE SHALL be ignored.
REQ-029 SHALL leave out_data unchanged except at REQ-024 capture and reset.

Reset
REQ-030 SHALL, on any edge with RST low, including mid-RUN or mid-DONE: state=IDLE, round=0, step=0, out_valid=0, out_data=0, dp_data=0.
REQ-031 SHALL hold in_ready=0 while RST is low; all dp_* outputs SHALL be 0 after reset.

Structure
REQ-032 SHALL take the FSM state enum, NR default and 4-bit round/key index width from shared package inv_aes_pkg.
REQ-033 SHALL place the step/round counter pair in one sub-module, aes_round_timer (inputs clear, enable; outputs round, step, last_step, last_round).

Verification
REQ-034 SHALL cover nominal: in_data=128'h936e8722476107bc0420fec84c77478a, stub dp_result=128'h1 -> key_idx 9,8..0 each 4 cycles, dp_load first 4 cycles only, dp_last last 4 only, out_valid at cycle 41, out_data=128'h1.
REQ-035 SHALL cover backpressure: out_ready low 5 cycles after out_valid -> out_valid, out_data stable, in_ready=0, busy=1; single handshake on release.
REQ-036 SHALL cover abort at RUN cycle 12 -> IDLE next cycle, in_ready=1, no out_valid, key_idx=0.
REQ-037 SHALL cover RST low at RUN cycle 20 -> next edge out_valid=0, out_data=0, dp_data=0, in_ready=0 until RST high.
REQ-038 SHALL cover back-to-back: in_valid held high, out_ready=1 -> second accept exactly one cycle after first output handshake.
REQ-039 SHALL cover STEP_CYCLES=1: key_idx changes every cycle, out_valid 11 cycles after accept.

Source files
------------

// File: rtl/inv_aes_pkg.sv
// Shared types and constants for the inverse-AES round controller.
package inv_aes_pkg;
  localparam int NR_DEFAULT = 10;
  localparam int IDX_W      = 4;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/aes_round_timer.sv
// Step/round counter pair: each round lasts STEP_CYCLES enabled cycles.
module aes_round_timer
  import inv_aes_pkg::*;
#(
  parameter int NR          = NR_DEFAULT,
  parameter int STEP_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       clear,
  input  logic       enable,
  output idx_t       round,
  output logic [3:0] step,
  output logic       last_step,
  output logic       last_round
);
  idx_t       round_q, round_d;
  logic [3:0] step_q, step_d;

  assign last_step  = (step_q == 4'(STEP_CYCLES - 1));
  assign last_round = (round_q == idx_t'(NR - 1));
  assign round      = round_q;
  assign step       = step_q;

  // Advance step; on step wrap advance round, wrapping to 0 after the last round.
  always_comb begin
    step_d  = step_q;
    round_d = round_q;
    if (clear) begin
      step_d  = '0;
      round_d = '0;
    end else if (enable) begin
      if (last_step) begin
        step_d  = '0;
        round_d = last_round ? '0 : round_q + idx_t'(1);
      end else begin
        step_d = step_q + 4'd1;
      end
    end
  end

  // Counter registers, synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      step_q  <= '0;
      round_q <= '0;
    end else begin
      step_q  <= step_d;
      round_q <= round_d;
    end
  end
endmodule

// File: rtl/inv_aes_round_ctrl.sv
// Inverse-AES round controller: sequences NR rounds of STEP_CYCLES each
// over an external datapath and hands the plaintext back with valid/ready.
module inv_aes_round_ctrl
  import inv_aes_pkg::*;
#(
  parameter int NR          = NR_DEFAULT,
  parameter int STEP_CYCLES = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         abort,
  output logic [127:0] dp_data,
  output logic [3:0]   key_idx,
  output logic [3:0]   dp_round,
  output logic         dp_load,
  output logic         dp_last,
  input  logic [127:0] dp_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  state_e       state_q, state_d;
  logic [127:0] dp_data_q, out_data_q;
  idx_t         round_w;
  logic [3:0]   step_w;
  logic         last_step_w, last_round_w;
  logic         run, accept, finish, tmr_clear;

  assign run       = (state_q == ST_RUN);
  assign in_ready  = (state_q == ST_IDLE) && RST;
  assign accept    = in_valid && in_ready;
  assign finish    = run && !abort && last_step_w && last_round_w;
  assign tmr_clear = accept || (run && abort);

  aes_round_timer #(
    .NR          (NR),
    .STEP_CYCLES (STEP_CYCLES)
  ) u_timer (
    .CLK        (CLK),
    .RST        (RST),
    .clear      (tmr_clear),
    .enable     (run),
    .round      (round_w),
    .step       (step_w),
    .last_step  (last_step_w),
    .last_round (last_round_w)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state: abort wins over completion in the final step.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN: begin
        if (abort)       state_d = ST_IDLE;
        else if (finish) state_d = ST_DONE;
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: datapath controls are only live in RUN.
  always_comb begin
    busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    out_valid = (state_q == ST_DONE);
    dp_round  = run ? round_w : '0;
    key_idx   = run ? (idx_t'(NR - 1) - round_w) : '0;
    dp_load   = run && (round_w == '0);
    dp_last   = run && last_round_w;
  end

  // Ciphertext captured on accept, plaintext captured on the final step edge.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      dp_data_q  <= '0;
      out_data_q <= '0;
    end else begin
      if (accept) dp_data_q  <= in_data;
      if (finish) out_data_q <= dp_result;
    end
  end

  assign dp_data  = dp_data_q;
  assign out_data = out_data_q;

  // The timer must sit at zero whenever no decryption is running.
  always_ff @(posedge CLK) begin
    if (RST && !run) assert (step_w == '0 && round_w == '0);
  end
endmodule

// File: tb/tb_inv_aes_round_ctrl.sv
// Directed bench for inv_aes_round_ctrl: default DUT (NR=10, STEP=4) plus a STEP=1 DUT.
module tb_inv_aes_round_ctrl;
  localparam logic [127:0] CT  = 128'h936e8722476107bc0420fec84c77478a;
  localparam logic [127:0] CT2 = 128'h0123456789abcdef0011223344556677;
  localparam logic [127:0] RES_B = 128'hcafe;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic         RST, abort, out_ready;
  logic [127:0] in_data;
  logic         a_in_valid, b_in_valid;

  logic         a_in_ready, a_dp_load, a_dp_last, a_out_valid, a_busy;
  logic [127:0] a_dp_data, a_out_data;
  logic [3:0]   a_key_idx, a_dp_round;
  logic         b_in_ready, b_dp_load, b_dp_last, b_out_valid, b_busy;
  logic [127:0] b_dp_data, b_out_data;
  logic [3:0]   b_key_idx, b_dp_round;

  inv_aes_round_ctrl u_a (
    .CLK(CLK), .RST(RST), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .abort(abort), .dp_data(a_dp_data), .key_idx(a_key_idx),
    .dp_round(a_dp_round), .dp_load(a_dp_load), .dp_last(a_dp_last),
    .dp_result(128'h1), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .busy(a_busy)
  );

  inv_aes_round_ctrl #(.NR(10), .STEP_CYCLES(1)) u_b (
    .CLK(CLK), .RST(RST), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .abort(abort), .dp_data(b_dp_data), .key_idx(b_key_idx),
    .dp_round(b_dp_round), .dp_load(b_dp_load), .dp_last(b_dp_last),
    .dp_result(RES_B), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .busy(b_busy)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    int n;
    int r;
    RST = 1'b0; abort = 1'b0; out_ready = 1'b0; in_data = '0;
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    @(negedge CLK);
    tick(); tick();

    // Reset state
    chk("rst_in_ready", 128'(a_in_ready), 128'd0);
    chk("rst_busy",     128'(a_busy),     128'd0);
    chk("rst_out_valid",128'(a_out_valid),128'd0);
    chk("rst_out_data", a_out_data,       128'd0);
    chk("rst_dp_data",  a_dp_data,        128'd0);
    chk("rst_key_idx",  128'(a_key_idx),  128'd0);
    chk("rst_dp_load",  128'(a_dp_load),  128'd0);
    RST = 1'b1;
    tick();
    chk("idle_in_ready", 128'(a_in_ready), 128'd1);

    // Nominal decryption with output backpressure
    in_data = CT; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0; in_data = '0;
    for (n = 1; n <= 41; n++) begin
      if (n <= 40) begin
        r = (n - 1) / 4;
        chk("nom_key_idx",  128'(a_key_idx),  128'(9 - r));
        chk("nom_dp_round", 128'(a_dp_round), 128'(r));
        chk("nom_dp_load",  128'(a_dp_load),  128'(r == 0));
        chk("nom_dp_last",  128'(a_dp_last),  128'(r == 9));
        chk("nom_out_valid",128'(a_out_valid),128'd0);
        chk("nom_dp_data",  a_dp_data,        CT);
      end else begin
        chk("nom_out_valid41", 128'(a_out_valid), 128'd1);
        chk("nom_out_data",    a_out_data,        128'h1);
        chk("done_key_idx",    128'(a_key_idx),   128'd0);
      end
      if (n < 41) tick();
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_out_valid", 128'(a_out_valid), 128'd1);
      chk("bp_out_data",  a_out_data,        128'h1);
      chk("bp_in_ready",  128'(a_in_ready),  128'd0);
      chk("bp_busy",      128'(a_busy),      128'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_out_valid", 128'(a_out_valid), 128'd0);
    chk("hs_in_ready",  128'(a_in_ready),  128'd1);
    chk("hs_busy",      128'(a_busy),      128'd0);
    tick();
    chk("hs_single",    128'(a_out_valid), 128'd0);

    // Abort at RUN cycle 12
    in_data = CT2; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    repeat (11) tick();
    chk("ab_key_idx_pre", 128'(a_key_idx), 128'd7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_in_ready",  128'(a_in_ready),  128'd1);
    chk("ab_out_valid", 128'(a_out_valid), 128'd0);
    chk("ab_key_idx",   128'(a_key_idx),   128'd0);
    chk("ab_busy",      128'(a_busy),      128'd0);
    chk("ab_out_data",  a_out_data,        128'h1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ab_no_valid", 128'(a_out_valid), 128'd0);
    end

    // Reset at RUN cycle 20
    in_data = CT; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    repeat (19) tick();
    chk("rr_busy_pre", 128'(a_busy), 128'd1);
    RST = 1'b0; a_in_valid = 1'b1;
    tick();
    chk("rr_out_valid", 128'(a_out_valid), 128'd0);
    chk("rr_out_data",  a_out_data,        128'd0);
    chk("rr_dp_data",   a_dp_data,         128'd0);
    chk("rr_in_ready",  128'(a_in_ready),  128'd0);
    chk("rr_busy",      128'(a_busy),      128'd0);
    chk("rr_key_idx",   128'(a_key_idx),   128'd0);
    tick();
    chk("rr_in_ready2", 128'(a_in_ready),  128'd0);
    chk("rr_busy2",     128'(a_busy),      128'd0);
    RST = 1'b1; a_in_valid = 1'b0;
    tick();
    chk("rr_in_ready_rel", 128'(a_in_ready), 128'd1);

    // Back-to-back: in_valid held, out_ready high
    out_ready = 1'b1; in_data = CT; a_in_valid = 1'b1;
    tick();
    in_data = CT2;
    n = 1;
    while (!a_out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("b2b_latency", 128'(n), 128'd41);
    tick();
    chk("b2b_hs_valid", 128'(a_out_valid), 128'd0);
    chk("b2b_in_ready", 128'(a_in_ready),  128'd1);
    chk("b2b_busy_gap", 128'(a_busy),      128'd0);
    tick();
    a_in_valid = 1'b0;
    chk("b2b_busy2",    128'(a_busy),      128'd1);
    chk("b2b_dp_data2", a_dp_data,         CT2);
    chk("b2b_dp_load2", 128'(a_dp_load),   128'd1);
    chk("b2b_key_idx2", 128'(a_key_idx),   128'd9);
    n = 0;
    while (!a_out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("b2b_drain", 128'(a_out_valid), 128'd1);
    tick();
    out_ready = 1'b0;

    // STEP_CYCLES = 1
    in_data = CT; b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    for (n = 1; n <= 11; n++) begin
      if (n <= 10) begin
        chk("s1_key_idx",  128'(b_key_idx),  128'(10 - n));
        chk("s1_dp_last",  128'(b_dp_last),  128'(n == 10));
        chk("s1_out_valid",128'(b_out_valid),128'd0);
      end else begin
        chk("s1_out_valid11", 128'(b_out_valid), 128'd1);
        chk("s1_out_data",    b_out_data,        RES_B);
      end
      if (n < 11) tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("s1_hs_valid", 128'(b_out_valid), 128'd0);
    chk("s1_in_ready", 128'(b_in_ready),  128'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
